tape_ram_injector: RTL and testbench

Downstream stage of the cassette TAP parser: consumes its `tape_addr`/`tape_wr`/`tape_dout`/`tape_complete` outputs and writes the bytes into main RAM through a small FIFO, in idle RAM slots only. When the parser signals completion, the block waits for the FIFO to drain, then injects a `JP exec` instruction (`C3 lo hi`) into the Z80's next opcode fetch. Loaded programs therefore start without CPU-side cooperation.

---
 rtl/tape_ram_if.sv | 35 +++
 rtl/tape_ram_injector.sv | 197 +++++++++++++++++++
 tb/tb_tape_ram_injector.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_ram_if.sv
// Bus bundle between the TAP parser / Z80 side and the RAM injector.
// Parser outputs, CPU bus status inputs, RAM write port and injection controls.
interface tape_ram_if;
    logic [15:0] tape_addr;
    logic        tape_wr;
    logic [7:0]  tape_dout;
    logic        tape_complete;
    logic        autostart;
    logic        cpu_ram_busy;
    logic        cpu_rd_done;
    logic        cpu_m1;

    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        cpu_wait;
    logic        inject_en;
    logic [7:0]  inject_data;
    logic        overflow;
    logic        busy;

    modport master (
        output tape_addr, tape_wr, tape_dout, tape_complete, autostart,
               cpu_ram_busy, cpu_rd_done, cpu_m1,
        input  ram_addr, ram_din, ram_we, cpu_wait, inject_en, inject_data,
               overflow, busy
    );

    modport slave (
        input  tape_addr, tape_wr, tape_dout, tape_complete, autostart,
               cpu_ram_busy, cpu_rd_done, cpu_m1,
        output ram_addr, ram_din, ram_we, cpu_wait, inject_en, inject_data,
               overflow, busy
    );
endinterface

// File: rtl/tape_ram_injector.sv
// Buffers TAP loader writes into idle RAM slots and, once loading completes,
// forces a JP <exec> into the Z80's next opcode fetch.
module tape_ram_injector #(
    parameter int unsigned DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    tape_ram_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]  JP_OPCODE = 8'hC3;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    // JP_OP is kept for encoding completeness; the opcode byte is served from ARM.
    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ARM,
        JP_OP,
        JP_LO,
        JP_HI
    } state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            prev_wr;
    logic            prev_tc;
    logic [15:0]     last_addr;
    logic            overflow_q;

    state_t          state;
    state_t          next_state;
    logic [15:0]     exec;
    logic [15:0]     exec_next;
    logic            inj_en_q;
    logic            inj_en_next;
    logic [7:0]      inj_data_q;
    logic [7:0]      inj_data_next;

    logic            empty;
    logic            full;
    logic            accept;
    logic            pop;
    logic            push;
    logic            tc_rise;
    entry_t          head;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A held write level only counts again when the address moves on.
    assign accept  = bus.tape_wr && (!prev_wr || (bus.tape_addr != last_addr));
    assign pop     = !empty && !bus.cpu_ram_busy;
    assign push    = accept && (!full || pop);
    assign tc_rise = bus.tape_complete && !prev_tc;
    assign head    = mem[rd_ptr];

    // Edge detectors, last-address tracker and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_wr    <= 1'b0;
            prev_tc    <= 1'b0;
            last_addr  <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            prev_wr <= bus.tape_wr;
            prev_tc <= bus.tape_complete;
            if (accept) begin
                last_addr <= bus.tape_addr;
            end
            if (accept && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'({bus.tape_addr, bus.tape_dout});
        end
    end

    // FSM and injection registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            exec       <= 16'h0000;
            inj_en_q   <= 1'b0;
            inj_data_q <= 8'h00;
        end else begin
            state      <= next_state;
            exec       <= exec_next;
            inj_en_q   <= inj_en_next;
            inj_data_q <= inj_data_next;
        end
    end

    always_comb begin
        next_state    = state;
        exec_next     = exec;
        inj_en_next   = 1'b0;
        inj_data_next = 8'h00;

        case (state)
            IDLE: begin
                if (tc_rise && bus.autostart) begin
                    exec_next  = bus.tape_addr;
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (tc_rise) begin
                    exec_next = bus.tape_addr;
                end else if (empty && !accept) begin
                    next_state = ARM;
                end
            end
            ARM: begin
                if (tc_rise) begin
                    exec_next  = bus.tape_addr;
                    next_state = DRAIN;
                end else if (bus.cpu_rd_done && bus.cpu_m1) begin
                    next_state = JP_LO;
                end
            end
            JP_LO: begin
                if (bus.cpu_rd_done) begin
                    next_state = JP_HI;
                end
            end
            JP_HI: begin
                if (bus.cpu_rd_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // Decode from next state so the byte is stable for the whole read.
        case (next_state)
            ARM: begin
                inj_en_next   = 1'b1;
                inj_data_next = JP_OPCODE;
            end
            JP_LO: begin
                inj_en_next   = 1'b1;
                inj_data_next = exec_next[7:0];
            end
            JP_HI: begin
                inj_en_next   = 1'b1;
                inj_data_next = exec_next[15:8];
            end
            default: ;
        endcase
    end

    assign bus.ram_we      = pop;
    assign bus.ram_addr    = pop ? head.addr : 16'h0000;
    assign bus.ram_din     = pop ? head.data : 8'h00;
    assign bus.cpu_wait    = (count >= CW'(DEPTH - 4)) || (state == DRAIN);
    // Only opcode fetches are overridden while waiting for the JP opcode slot.
    assign bus.inject_en   = inj_en_q && (bus.cpu_m1 || (state != ARM));
    assign bus.inject_data = inj_data_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = !empty || (state != IDLE);

endmodule

// File: tb/tb_tape_ram_injector.sv
// Directed and random checks of tape_ram_injector against a queue-based model
// of the loader FIFO and a byte-list model of the pending JP injection.
module tb_tape_ram_injector;

    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tape_ram_if bus ();

    tape_ram_injector #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: FIFO contents, sticky overflow, and the JP bytes still to be served.
    ent_t        mq[$];
    bit          m_ovf;
    bit          m_prev_wr;
    bit          m_prev_tc;
    logic [15:0] m_last;
    bit          m_pending;
    bit          m_armed;
    logic [7:0]  m_jbytes[$];
    logic [15:0] m_exec;

    ent_t        got_q[$];
    int          got_cyc[$];
    logic [7:0]  inj_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_jbytes.delete();
        m_ovf     = 1'b0;
        m_prev_wr = 1'b0;
        m_prev_tc = 1'b0;
        m_last    = 16'h0000;
        m_pending = 1'b0;
        m_armed   = 1'b0;
        m_exec    = 16'h0000;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, then move past the edge.
    task automatic step();
        bit          e_we;
        bit          acc;
        bit          tcr;
        bit          room;
        bit          e_inj_en;
        logic [7:0]  e_inj_d;
        ent_t        h;
        @(negedge clk);
        e_we = (mq.size() > 0) && !bus.cpu_ram_busy;
        h    = e_we ? mq[0] : ent_t'(24'h0);
        chk("ram_we",   32'(bus.ram_we),   32'(e_we));
        chk("ram_addr", 32'(bus.ram_addr), 32'(h.a));
        chk("ram_din",  32'(bus.ram_din),  32'(h.d));
        chk("cpu_wait", 32'(bus.cpu_wait), 32'((mq.size() >= DEPTH - 4) || (m_pending && !m_armed)));
        chk("busy",     32'(bus.busy),     32'((mq.size() > 0) || m_pending));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        e_inj_en = m_armed && ((m_jbytes.size() != 3) || bus.cpu_m1);
        e_inj_d  = m_armed ? m_jbytes[0] : 8'h00;
        chk("inject_en",   32'(bus.inject_en),   32'(e_inj_en));
        chk("inject_data", 32'(bus.inject_data), 32'(e_inj_d));
        if (bus.ram_we) begin
            got_q.push_back(ent_t'({bus.ram_addr, bus.ram_din}));
            got_cyc.push_back(cyc);
        end
        if (bus.cpu_rd_done && bus.inject_en) inj_q.push_back(bus.inject_data);

        if (reset) begin
            model_clear();
        end else begin
            acc = bus.tape_wr && (!m_prev_wr || (bus.tape_addr != m_last));
            tcr = bus.tape_complete && !m_prev_tc;
            if (m_pending && !m_armed) begin
                if (tcr) m_exec = bus.tape_addr;
                else if ((mq.size() == 0) && !acc) begin
                    m_armed = 1'b1;
                    m_jbytes.delete();
                    m_jbytes.push_back(8'hC3);
                    m_jbytes.push_back(m_exec[7:0]);
                    m_jbytes.push_back(m_exec[15:8]);
                end
            end else if (m_armed) begin
                if ((m_jbytes.size() == 3) && tcr) begin
                    m_armed = 1'b0;
                    m_exec  = bus.tape_addr;
                end else if (bus.cpu_rd_done && ((m_jbytes.size() != 3) || bus.cpu_m1)) begin
                    void'(m_jbytes.pop_front());
                    if (m_jbytes.size() == 0) begin
                        m_armed   = 1'b0;
                        m_pending = 1'b0;
                    end
                end
            end else if (tcr && bus.autostart) begin
                m_pending = 1'b1;
                m_exec    = bus.tape_addr;
            end
            room = (mq.size() < DEPTH) || e_we;
            if (e_we) void'(mq.pop_front());
            if (acc) begin
                if (room) mq.push_back(ent_t'({bus.tape_addr, bus.tape_dout}));
                else      m_ovf = 1'b1;
                m_last = bus.tape_addr;
            end
            m_prev_wr = bus.tape_wr;
            m_prev_tc = bus.tape_complete;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        inj_q.delete();
    endtask

    // CPU read pulses every third cycle; M1 alternates so ARM also sees non-M1 reads.
    task automatic cpu_reads(input int n, input int stop_after);
        bit m1 = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (inj_q.size() >= stop_after) break;
            bus.cpu_rd_done = ((k % 3) == 2);
            if (bus.cpu_rd_done) m1 = ~m1;
            bus.cpu_m1 = m1;
            step();
        end
        bus.cpu_rd_done = 1'b0;
        bus.cpu_m1      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        bus.tape_addr     = 16'h0000;
        bus.tape_wr       = 1'b0;
        bus.tape_dout     = 8'h00;
        bus.tape_complete = 1'b0;
        bus.autostart     = 1'b0;
        bus.cpu_ram_busy  = 1'b0;
        bus.cpu_rd_done   = 1'b0;
        bus.cpu_m1        = 1'b0;
        reset             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_inj",  32'(bus.inject_en), 32'd0);

        // Held write level across three addresses.
        clear_logs();
        bus.tape_wr = 1'b1;
        bus.tape_addr = 16'h694D; bus.tape_dout = 8'h11; step(); step();
        bus.tape_addr = 16'h694E; bus.tape_dout = 8'h22; step(); step();
        bus.tape_addr = 16'h694F; bus.tape_dout = 8'h33; step(); step();
        bus.tape_wr = 1'b0;
        repeat (3) step();
        chk("cap_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("cap0", 32'(got_q[0]), 32'h694D11);
            chk("cap1", 32'(got_q[1]), 32'h694E22);
            chk("cap2", 32'(got_q[2]), 32'h694F33);
        end

        // Four queued bytes held off by CPU RAM ownership for ten cycles.
        clear_logs();
        bus.cpu_ram_busy = 1'b1;
        bus.tape_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tape_addr = 16'h1000 + 16'(i);
            bus.tape_dout = 8'hA0 + 8'(i);
            step();
        end
        bus.tape_wr = 1'b0;
        repeat (6) step();
        bus.cpu_ram_busy = 1'b0;
        rel = cyc;
        repeat (6) step();
        chk("arb_n", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("arb_first_cyc", 32'(got_cyc[0]), 32'(rel));
            chk("arb_consec",    32'(got_cyc[3] - got_cyc[0]), 32'd3);
            chk("arb_last",      32'(got_q[3]), 32'h1003A3);
        end

        // DEPTH+1 writes while the RAM port is unavailable.
        clear_logs();
        bus.cpu_ram_busy = 1'b1;
        bus.tape_wr = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.tape_addr = 16'h2000 + 16'(i);
            bus.tape_dout = 8'(i) ^ 8'h5A;
            step();
            if (i == 10) chk("ovf_wait11", 32'(bus.cpu_wait), 32'd0);
            if (i == 11) chk("ovf_wait12", 32'(bus.cpu_wait), 32'd1);
            if (i == 15) chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
        end
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        bus.tape_wr = 1'b0;
        bus.cpu_ram_busy = 1'b0;
        repeat (20) step();
        chk("ovf_n", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            chk("ovf_first", 32'(got_q[0]),  32'h20005A);
            chk("ovf_last",  32'(got_q[15]), 32'h200F55);
        end
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Autostart with two bytes pending, then autostart disabled.
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            bus.autostart = (pass == 0);
            bus.cpu_ram_busy = 1'b1;
            bus.tape_wr = 1'b1;
            bus.tape_addr = 16'h3000; bus.tape_dout = 8'hAA; step();
            bus.tape_addr = 16'h3001; bus.tape_dout = 8'hBB; step();
            bus.tape_wr = 1'b0;
            bus.tape_complete = 1'b1;
            bus.tape_addr = 16'h0CC1;
            step();
            chk("as_wait", 32'(bus.cpu_wait), 32'(pass == 0));
            bus.tape_complete = 1'b0;
            bus.cpu_ram_busy = 1'b0;
            cpu_reads(60, 3);
            repeat (2) step();
            chk("as_writes", 32'(got_q.size()), 32'd2);
            if (pass == 0) begin
                chk("as_nbytes", 32'(inj_q.size()), 32'd3);
                if (inj_q.size() == 3) begin
                    chk("as_op", 32'(inj_q[0]), 32'hC3);
                    chk("as_lo", 32'(inj_q[1]), 32'hC1);
                    chk("as_hi", 32'(inj_q[2]), 32'h0C);
                end
                chk("as_idle", 32'(bus.busy), 32'd0);
            end else begin
                chk("off_nbytes", 32'(inj_q.size()), 32'd0);
            end
        end

        // Reset while the low exec byte is being served.
        clear_logs();
        bus.autostart = 1'b1;
        bus.tape_addr = 16'h1234;
        bus.tape_complete = 1'b1;
        step();
        bus.tape_complete = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (m_armed && (m_jbytes.size() == 2)) break;
            bus.cpu_rd_done = ((k % 3) == 2);
            bus.cpu_m1 = 1'b1;
            step();
        end
        bus.cpu_rd_done = 1'b0;
        chk("jplo_data", 32'(bus.inject_data), 32'h34);
        do_reset();
        bus.cpu_m1 = 1'b0;
        chk("rst_mid_inj",  32'(bus.inject_en), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_mid_wait", 32'(bus.cpu_wait), 32'd0);
        step();

        // Random traffic against the model.
        bus.autostart = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) bus.tape_wr = ~bus.tape_wr;
            if ($urandom_range(0, 1) == 0) bus.tape_addr = 16'h4000 + 16'($urandom_range(0, 7));
            bus.tape_dout     = 8'($urandom);
            bus.cpu_ram_busy  = ($urandom_range(0, 2) == 0);
            bus.cpu_rd_done   = ($urandom_range(0, 3) == 0);
            bus.cpu_m1        = 1'($urandom);
            if ($urandom_range(0, 63) == 0)  bus.tape_complete = ~bus.tape_complete;
            if ($urandom_range(0, 255) == 0) bus.autostart = ~bus.autostart;
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
